// File: rtl/ysyx_23060025_trap_ctrl_pkg.sv
// Shared constants for the trap controller: op codes, machine CSR addresses,
// mstatus bit positions, the timer-interrupt cause code and FSM state encodings.
package ysyx_23060025_trap_ctrl_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_CSRRW = 3'd1;
    localparam logic [2:0] OP_CSRRS = 3'd2;
    localparam logic [2:0] OP_CSRRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Machine timer interrupt; the interrupt flag is the MSB of the cause word.
    localparam int unsigned IRQ_CAUSE_CODE = 7;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_CSR_RD      = 4'd1;
    localparam logic [3:0] ST_CSR_WR      = 4'd2;
    localparam logic [3:0] ST_TRAP_EPC    = 4'd3;
    localparam logic [3:0] ST_TRAP_CAUSE  = 4'd4;
    localparam logic [3:0] ST_TRAP_STATUS = 4'd5;
    localparam logic [3:0] ST_TRAP_VEC    = 4'd6;
    localparam logic [3:0] ST_MRET_STATUS = 4'd7;
    localparam logic [3:0] ST_MRET_PC     = 4'd8;

endpackage

// File: rtl/ysyx_23060025_trap_ctrl_csr_alu.sv
// New CSR value for the Zicsr read-modify-write ops (swap / set bits / clear bits).
module ysyx_23060025_csr_alu
    import ysyx_23060025_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] old_val,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] new_val
);

    always_comb begin
        new_val = old_val;
        case (op)
            OP_CSRRW: new_val = wdata;
            OP_CSRRS: new_val = old_val | wdata;
            OP_CSRRC: new_val = old_val & ~wdata;
            default:  new_val = old_val;
        endcase
    end

endmodule

// File: rtl/ysyx_23060025_trap_ctrl.sv
// Trap / CSR controller: sequences CSR instructions, ECALL, MRET and the machine
// timer interrupt as one CSR-file access per cycle, and issues PC redirects.
module ysyx_23060025_trap_ctrl
    import ysyx_23060025_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [11:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_pc,
    input  logic [DATA_WIDTH-1:0] req_cause,
    input  logic                  irq,
    input  logic [DATA_WIDTH-1:0] irq_pc,
    output logic [11:0]           csr_addr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  csr_we_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam logic [DATA_WIDTH-1:0] IRQ_CAUSE = {1'b1, (DATA_WIDTH-1)'(IRQ_CAUSE_CODE)};

    logic [3:0]            state_q, state_d;
    logic                  mie_q, mie_d;
    logic                  none_q, none_d;
    logic [2:0]            op_q, op_d;
    logic [11:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_WIDTH-1:0] old_q, old_d;
    logic [DATA_WIDTH-1:0] alu_new;
    logic                  irq_taken;

    function automatic logic [DATA_WIDTH-1:0] trap_status(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mret_status(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    ysyx_23060025_csr_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_csr_alu (
        .op      (op_q),
        .old_val (old_q),
        .wdata   (wdata_q),
        .new_val (alu_new)
    );

    assign irq_taken = (state_q == ST_IDLE) && irq && mie_q;

    always_comb begin
        state_d        = state_q;
        mie_d          = mie_q;
        none_d         = 1'b0;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        old_d          = old_q;
        req_ready      = 1'b0;
        csr_addr_o     = '0;
        csr_wdata_o    = '0;
        csr_we_o       = 1'b0;
        rsp_valid      = none_q;
        rsp_rdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = !irq_taken;
                if (irq_taken) begin
                    epc_d   = irq_pc;
                    cause_d = IRQ_CAUSE;
                    state_d = ST_TRAP_EPC;
                end else if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    epc_d   = req_pc;
                    cause_d = req_cause;
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = ST_CSR_RD;
                        OP_ECALL: state_d = ST_TRAP_EPC;
                        OP_MRET:  state_d = ST_MRET_STATUS;
                        default:  none_d  = 1'b1;
                    endcase
                end
            end
            ST_CSR_RD: begin
                csr_addr_o = addr_q;
                old_d      = csr_rdata_i;
                state_d    = ST_CSR_WR;
            end
            ST_CSR_WR: begin
                csr_addr_o  = addr_q;
                csr_wdata_o = alu_new;
                csr_we_o    = 1'b1;
                rsp_valid   = 1'b1;
                rsp_rdata   = old_q;
                state_d     = ST_IDLE;
            end
            ST_TRAP_EPC: begin
                csr_addr_o  = CSR_MEPC;
                csr_wdata_o = epc_q;
                csr_we_o    = 1'b1;
                state_d     = ST_TRAP_CAUSE;
            end
            ST_TRAP_CAUSE: begin
                csr_addr_o  = CSR_MCAUSE;
                csr_wdata_o = cause_q;
                csr_we_o    = 1'b1;
                state_d     = ST_TRAP_STATUS;
            end
            ST_TRAP_STATUS: begin
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = trap_status(csr_rdata_i);
                csr_we_o    = 1'b1;
                state_d     = ST_TRAP_VEC;
            end
            ST_TRAP_VEC: begin
                csr_addr_o     = CSR_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata_i[DATA_WIDTH-1:2], 2'b00};
                rsp_valid      = 1'b1;
                state_d        = ST_IDLE;
            end
            ST_MRET_STATUS: begin
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = mret_status(csr_rdata_i);
                csr_we_o    = 1'b1;
                state_d     = ST_MRET_PC;
            end
            ST_MRET_PC: begin
                csr_addr_o     = CSR_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata_i;
                rsp_valid      = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The shadow copy of MIE follows whatever this controller writes to mstatus.
        if (csr_we_o && (csr_addr_o == CSR_MSTATUS)) begin
            mie_d = csr_wdata_o[MSTATUS_MIE];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mie_q   <= 1'b0;
            none_q  <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            epc_q   <= '0;
            cause_q <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            mie_q   <= mie_d;
            none_q  <= none_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            old_q   <= old_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_trap_ctrl.sv
// Self-checking bench for ysyx_23060025_trap_ctrl with a small CSR-file model
// and a response scoreboard (expected responses queued at request time).
module tb_ysyx_23060025_trap_ctrl;
    import ysyx_23060025_trap_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0, req_pc = '0, req_cause = '0;
    logic        irq = 1'b0;
    logic [31:0] irq_pc = '0;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o, csr_rdata_i, rsp_rdata, redirect_pc;
    logic        csr_we_o, rsp_valid, redirect_valid;

    typedef struct {
        logic        redirect;
        logic [31:0] rdata;
        logic [31:0] pc;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    ysyx_23060025_trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_pc         (req_pc),
        .req_cause      (req_cause),
        .irq            (irq),
        .irq_pc         (irq_pc),
        .csr_addr_o     (csr_addr_o),
        .csr_wdata_o    (csr_wdata_o),
        .csr_we_o       (csr_we_o),
        .csr_rdata_i    (csr_rdata_i),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // CSR file model: combinational read, write on the clock edge, plus a backdoor poke port.
    logic [31:0] csr_mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          wr_cnt = 0;
    int          mstatus_wr_cnt = 0;
    int          cyc = 0;
    int          rsp_cnt = 0, rsp_run = 0, rsp_max_run = 0;
    int          redir_run = 0, redir_max_run = 0;

    assign csr_rdata_i = csr_mem[csr_addr_o];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bd_we) begin
            csr_mem[bd_addr] <= bd_data;
        end else if (csr_we_o) begin
            csr_mem[csr_addr_o] <= csr_wdata_o;
            wr_cnt <= wr_cnt + 1;
            if (csr_addr_o == 12'h300) mstatus_wr_cnt <= mstatus_wr_cnt + 1;
        end
    end

    always @(negedge clock) begin
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            rsp_run <= rsp_run + 1;
            if (rsp_run + 1 > rsp_max_run) rsp_max_run <= rsp_run + 1;
        end else begin
            rsp_run <= 0;
        end
        if (redirect_valid) begin
            redir_run <= redir_run + 1;
            if (redir_run + 1 > redir_max_run) redir_max_run <= redir_run + 1;
        end else begin
            redir_run <= 0;
        end
    end

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    // Presents a request and returns the cycle in which it was accepted.
    task automatic drive_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                             input logic [31:0] pc, input logic [31:0] cause,
                             output int acc, output bit ok);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc; req_cause = cause;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(posedge clock); #1;
        end
        acc = cyc;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit seen, output int at);
        seen = 1'b0; at = 0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) begin seen = 1'b1; at = cyc; break; end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        poke(12'h300, 32'h0000_1800);
        poke(12'h305, 32'h8000_0100);
        poke(12'h341, 32'h0);
        poke(12'h342, 32'h0);
        poke(12'h340, 32'h1234_5678);
        total++;
        if ({rsp_valid, redirect_valid, csr_we_o, csr_addr_o, csr_wdata_o, rsp_rdata, redirect_pc} !== '0) begin
            bad++; $display("[TB] FAIL reset_outputs: got we=%b addr=%h wd=%h rsp=%b redir=%b want all 0",
                            csr_we_o, csr_addr_o, csr_wdata_o, rsp_valid, redirect_valid);
        end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
        total++;
        if ({csr_addr_o, csr_wdata_o} !== '0) begin
            bad++; $display("[TB] FAIL idle_csr_bus: got addr=%h wd=%h want 0", csr_addr_o, csr_wdata_o);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] old;
        logic [31:0] nv;
    } op_t;

    task automatic test_csr_ops();
        op_t tbl[5];
        exp_t e;
        int acc, at;
        bit ok, seen;
        tbl[0] = '{OP_CSRRS, 12'h300, 32'h0000_0008, 32'h0000_1800, 32'h0000_1808};
        tbl[1] = '{OP_CSRRW, 12'h340, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF};
        tbl[2] = '{OP_CSRRC, 12'h340, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hDEAD_0000};
        tbl[3] = '{OP_CSRRS, 12'h340, 32'h0000_0000, 32'hDEAD_0000, 32'hDEAD_0000};
        tbl[4] = '{OP_CSRRC, 12'h340, 32'h0000_0000, 32'hDEAD_0000, 32'hDEAD_0000};
        for (int i = 0; i < 5; i++) begin
            drive_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, 32'h0, 32'h0, acc, ok);
            sb.push_back('{1'b0, tbl[i].old, 32'h0, acc});
            wait_rsp(10, seen, at);
            total++;
            if (!ok || !seen || sb.size() == 0) begin
                bad++; $display("[TB] FAIL csr_op%0d_rsp: got ok=%b seen=%b want 1", i, ok, seen);
                sb.delete();
                continue;
            end
            e = sb.pop_front();
            total++;
            if (rsp_rdata !== e.rdata) begin
                bad++; $display("[TB] FAIL csr_op%0d_rdata: got %h want %h", i, rsp_rdata, e.rdata);
            end
            total++;
            if (at - e.acc != 2) begin bad++; $display("[TB] FAIL csr_op%0d_latency: got %0d want 2", i, at - e.acc); end
            total++;
            if ({redirect_valid, csr_we_o, csr_addr_o, csr_wdata_o} !== {1'b0, 1'b1, tbl[i].addr, tbl[i].nv}) begin
                bad++; $display("[TB] FAIL csr_op%0d_write: got redir=%b we=%b addr=%h wd=%h want 0/1/%h/%h",
                                i, redirect_valid, csr_we_o, csr_addr_o, csr_wdata_o, tbl[i].addr, tbl[i].nv);
            end
            @(posedge clock); #1;
            total++;
            if (csr_mem[tbl[i].addr] !== tbl[i].nv) begin
                bad++; $display("[TB] FAIL csr_op%0d_mem: got %h want %h", i, csr_mem[tbl[i].addr], tbl[i].nv);
            end
        end
    endtask

    task automatic test_none();
        logic [2:0] ops[2];
        exp_t e;
        int acc, at, w0;
        bit ok, seen;
        ops[0] = OP_NONE;
        ops[1] = 3'd7;
        w0 = wr_cnt;
        for (int i = 0; i < 2; i++) begin
            drive_req(ops[i], 12'h340, 32'hFFFF_FFFF, 32'h0, 32'h0, acc, ok);
            sb.push_back('{1'b0, 32'h0, 32'h0, acc});
            wait_rsp(5, seen, at);
            total++;
            if (!ok || !seen || sb.size() == 0) begin
                bad++; $display("[TB] FAIL none%0d_rsp: got ok=%b seen=%b want 1", i, ok, seen);
                sb.delete();
                continue;
            end
            e = sb.pop_front();
            total++;
            if (rsp_rdata !== e.rdata) begin bad++; $display("[TB] FAIL none%0d_rdata: got %h want %h", i, rsp_rdata, e.rdata); end
            total++;
            if (at - e.acc != 1) begin bad++; $display("[TB] FAIL none%0d_latency: got %0d want 1", i, at - e.acc); end
            @(posedge clock); #1;
        end
        total++;
        if (wr_cnt != w0) begin bad++; $display("[TB] FAIL none_no_write: got %0d writes want 0", wr_cnt - w0); end
    endtask

    task automatic test_ecall();
        exp_t e;
        int acc, at;
        bit ok, seen;
        drive_req(OP_ECALL, 12'h0, 32'h0, 32'h8000_0010, 32'd11, acc, ok);
        sb.push_back('{1'b1, 32'h0, 32'h8000_0100, acc});
        wait_rsp(10, seen, at);
        total++;
        if (!ok || !seen) begin
            bad++; $display("[TB] FAIL ecall_rsp: got ok=%b seen=%b want 1", ok, seen);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++;
            if ({redirect_valid, redirect_pc, rsp_rdata} !== {e.redirect, e.pc, e.rdata}) begin
                bad++; $display("[TB] FAIL ecall_redirect: got v=%b pc=%h rd=%h want %b %h %h",
                                redirect_valid, redirect_pc, rsp_rdata, e.redirect, e.pc, e.rdata);
            end
            total++;
            if (at - e.acc != 4) begin bad++; $display("[TB] FAIL ecall_latency: got %0d want 4", at - e.acc); end
        end
        @(posedge clock); #1;
        total++;
        if ({csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]} !== {32'h8000_0010, 32'd11, 32'h0000_1880}) begin
            bad++; $display("[TB] FAIL ecall_csrs: got mepc=%h mcause=%h mstatus=%h want 80000010 0000000b 00001880",
                            csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]);
        end
    endtask

    task automatic test_mret();
        exp_t e;
        int acc, at;
        bit ok, seen;
        drive_req(OP_CSRRW, 12'h341, 32'h8000_0014, 32'h0, 32'h0, acc, ok);
        sb.push_back('{1'b0, 32'h8000_0010, 32'h0, acc});
        wait_rsp(10, seen, at);
        total++;
        if (!seen || (rsp_rdata !== sb[0].rdata)) begin
            bad++; $display("[TB] FAIL mepc_write_rdata: got seen=%b rd=%h want 1 %h", seen, rsp_rdata, sb[0].rdata);
        end
        sb.delete();
        @(posedge clock); #1;
        drive_req(OP_MRET, 12'h0, 32'h0, 32'h0, 32'h0, acc, ok);
        sb.push_back('{1'b1, 32'h0, 32'h8000_0014, acc});
        wait_rsp(10, seen, at);
        total++;
        if (!ok || !seen) begin
            bad++; $display("[TB] FAIL mret_rsp: got ok=%b seen=%b want 1", ok, seen);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++;
            if ({redirect_valid, redirect_pc, rsp_rdata} !== {e.redirect, e.pc, e.rdata}) begin
                bad++; $display("[TB] FAIL mret_redirect: got v=%b pc=%h rd=%h want %b %h %h",
                                redirect_valid, redirect_pc, rsp_rdata, e.redirect, e.pc, e.rdata);
            end
            total++;
            if (at - e.acc != 2) begin bad++; $display("[TB] FAIL mret_latency: got %0d want 2", at - e.acc); end
        end
        @(posedge clock); #1;
        total++;
        if (csr_mem[12'h300] !== 32'h0000_1888) begin
            bad++; $display("[TB] FAIL mret_mstatus: got %h want 00001888", csr_mem[12'h300]);
        end
    endtask

    task automatic test_irq_taken();
        exp_t e;
        int acc_irq, acc, at;
        bit ok, seen;
        irq_pc = 32'h8000_0040;
        irq = 1'b1;
        req_valid = 1'b1; req_op = OP_CSRRW; req_addr = 12'h340; req_wdata = 32'hA5A5_A5A5;
        #0;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL irq_blocks_ready: got %b want 0", req_ready); end
        acc_irq = cyc;
        sb.push_back('{1'b1, 32'h0, 32'h8000_0100, acc_irq});
        @(posedge clock); #1;
        irq = 1'b0;
        wait_rsp(10, seen, at);
        total++;
        if (!seen) begin
            bad++; $display("[TB] FAIL irq_rsp: got seen=0 want 1");
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++;
            if ({redirect_valid, redirect_pc} !== {e.redirect, e.pc}) begin
                bad++; $display("[TB] FAIL irq_redirect: got v=%b pc=%h want %b %h", redirect_valid, redirect_pc, e.redirect, e.pc);
            end
            total++;
            if (at - e.acc != 4) begin bad++; $display("[TB] FAIL irq_latency: got %0d want 4", at - e.acc); end
        end
        drive_req(OP_CSRRW, 12'h340, 32'hA5A5_A5A5, 32'h0, 32'h0, acc, ok);
        total++;
        if (!ok || acc != acc_irq + 5) begin
            bad++; $display("[TB] FAIL irq_held_req_accept: got cycle %0d want %0d", acc - acc_irq, 5);
        end
        sb.push_back('{1'b0, 32'hDEAD_0000, 32'h0, acc});
        wait_rsp(10, seen, at);
        total++;
        if (!seen || sb.size() == 0) begin
            bad++; $display("[TB] FAIL irq_held_req_rsp: got seen=%b want 1", seen);
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (rsp_rdata !== e.rdata || at - e.acc != 2) begin
                bad++; $display("[TB] FAIL irq_held_req_data: got rd=%h lat=%0d want %h 2", rsp_rdata, at - e.acc, e.rdata);
            end
        end
        @(posedge clock); #1;
        total++;
        if ({csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]} !== {32'h8000_0040, 32'h8000_0007, 32'h0000_1880}) begin
            bad++; $display("[TB] FAIL irq_csrs: got mepc=%h mcause=%h mstatus=%h want 80000040 80000007 00001880",
                            csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]);
        end
    endtask

    task automatic test_irq_masked();
        exp_t e;
        int acc, at;
        bit ok, seen;
        irq_pc = 32'h8000_0080;
        irq = 1'b1;
        #0;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL irq_masked_ready: got %b want 1", req_ready); end
        drive_req(OP_CSRRW, 12'h340, 32'h1111_1111, 32'h0, 32'h0, acc, ok);
        sb.push_back('{1'b0, 32'hA5A5_A5A5, 32'h0, acc});
        wait_rsp(10, seen, at);
        total++;
        if (!ok || !seen || sb.size() == 0) begin
            bad++; $display("[TB] FAIL irq_masked_rsp: got ok=%b seen=%b want 1", ok, seen);
            sb.delete();
        end else begin
            e = sb.pop_front();
            if ({redirect_valid, rsp_rdata} !== {1'b0, e.rdata} || at - e.acc != 2) begin
                bad++; $display("[TB] FAIL irq_masked_data: got redir=%b rd=%h lat=%0d want 0 %h 2",
                                redirect_valid, rsp_rdata, at - e.acc, e.rdata);
            end
        end
        @(posedge clock); #1;
        irq = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc, m0, r0;
        bit ok;
        m0 = mstatus_wr_cnt;
        r0 = rsp_cnt;
        drive_req(OP_ECALL, 12'h0, 32'h0, 32'h8000_0020, 32'd2, acc, ok);
        @(posedge clock); #1;
        total++;
        if ({csr_we_o, csr_addr_o} !== {1'b1, 12'h342}) begin
            bad++; $display("[TB] FAIL reset_mid_in_cause: got we=%b addr=%h want 1 342", csr_we_o, csr_addr_o);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({rsp_valid, redirect_valid, csr_we_o, csr_addr_o, csr_wdata_o, rsp_rdata, redirect_pc} !== '0) begin
            bad++; $display("[TB] FAIL reset_mid_outputs: got we=%b addr=%h wd=%h want all 0", csr_we_o, csr_addr_o, csr_wdata_o);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_mid_ready: got %b want 1", req_ready); end
        total++;
        if (mstatus_wr_cnt != m0 || csr_mem[12'h300] !== 32'h0000_1880 || csr_mem[12'h342] !== 32'h8000_0007) begin
            bad++; $display("[TB] FAIL reset_mid_no_write: got mstatus=%h mcause=%h want 00001880 80000007",
                            csr_mem[12'h300], csr_mem[12'h342]);
        end
        total++;
        if (rsp_cnt != r0) begin bad++; $display("[TB] FAIL reset_mid_no_rsp: got %0d want 0", rsp_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd[3];
        logic [31:0] old[3];
        exp_t e;
        int idx, got, r0;
        wd[0] = 32'h0000_0001; wd[1] = 32'h0000_0002; wd[2] = 32'h0000_0003;
        old[0] = 32'h1111_1111; old[1] = 32'h0000_0001; old[2] = 32'h0000_0002;
        idx = 0; got = 0; r0 = rsp_cnt;
        req_valid = 1'b1; req_op = OP_CSRRW; req_addr = 12'h340; req_wdata = wd[0];
        for (int c = 0; c < 30 && got < 3; c++) begin
            if (rsp_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL b2b_unexpected_rsp: got rsp with empty queue want none");
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata !== e.rdata || cyc - e.acc != 2) begin
                        bad++; $display("[TB] FAIL b2b_rsp%0d: got rd=%h lat=%0d want %h 2", got, rsp_rdata, cyc - e.acc, e.rdata);
                    end
                end
                got++;
            end
            if (req_valid && req_ready) begin
                sb.push_back('{1'b0, old[idx], 32'h0, cyc});
                idx++;
            end
            @(posedge clock); #1;
            if (idx == 3) req_valid = 1'b0;
            else req_wdata = wd[idx];
        end
        req_valid = 1'b0;
        @(posedge clock); #1;
        total++;
        if (got != 3 || rsp_cnt - r0 != 3) begin
            bad++; $display("[TB] FAIL b2b_count: got %0d/%0d want 3", got, rsp_cnt - r0);
        end
        total++;
        if (rsp_max_run != 1 || redir_max_run != 1) begin
            bad++; $display("[TB] FAIL pulse_width: got rsp=%0d redir=%0d want 1 1", rsp_max_run, redir_max_run);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_csr_ops();
        test_none();
        test_ecall();
        test_mret();
        test_irq_taken();
        test_irq_masked();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
